// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Pipeline control for the 5-stage MIPS core. Tracks the destination register
// of each in-flight instruction in the EX, MEM and WB slots and, from that
// state plus the decode-stage fields, produces:
//   - a same-cycle load-use stall (hold PC and IF/ID, bubble into EX),
//   - a same-cycle flush of the ID instruction on a taken branch/jump,
//   - registered per-operand forwarding selects that line up with the
//     instruction's EX cycle,
//   - a saturating count of load-use stall cycles.
//
// Ports:
//   clk, rst_n         core clock (rising edge), async active-low reset
//   idValid            ID holds a real instruction (not a bubble)
//   idRs, idRt         source register fields of the ID instruction
//   idUsesRs/idUsesRt  the instruction actually reads that operand
//   idWritesRegister   the instruction writes the register file
//   idDestination      final write address (31 for jal, rt or rd otherwise)
//   idIsLoad           the instruction is lw
//   branchTaken        EX resolved a taken branch/jump this cycle
//   shouldStall        load-use stall, combinational on ID
//   shouldFlush        squash the ID instruction (equals branchTaken)
//   forwardRs/Rt       EX operand select: 00 regfile, 01 MEM ALU result,
//                      10 WB write data
//   stallCount         saturating number of load-use stall cycles
//
// Interface timing: there is no valid/ready handshake here. ID fields are
// sampled every rising edge; idValid=0 simply sends a bubble down the pipe.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         idValid,
  input  logic [REG_ADDR_WIDTH-1:0]    idRs,
  input  logic [REG_ADDR_WIDTH-1:0]    idRt,
  input  logic                         idUsesRs,
  input  logic                         idUsesRt,
  input  logic                         idWritesRegister,
  input  logic [REG_ADDR_WIDTH-1:0]    idDestination,
  input  logic                         idIsLoad,
  input  logic                         branchTaken,
  output logic                         shouldStall,
  output logic                         shouldFlush,
  output logic [1:0]                   forwardRs,
  output logic [1:0]                   forwardRt,
  output logic [STALL_COUNT_WIDTH-1:0] stallCount
);

  typedef struct packed {
    logic                      valid;
    logic                      writes;
    logic                      isLoad;
    logic [REG_ADDR_WIDTH-1:0] dest;
  } slotT;

  localparam int SlotEx  = 0;
  localparam int SlotMem = 1;
  localparam int SlotWb  = 2;

  localparam logic [1:0] FwdRegFile = 2'b00;
  localparam logic [1:0] FwdMem     = 2'b01;
  localparam logic [1:0] FwdWb      = 2'b10;

  // Occupancy of EX, MEM and WB. The WB slot completes the picture of what is
  // in flight; no select needs it because the register file is written before
  // it is read in the same cycle.
  slotT pipe [3];

  slotT       idSlot;
  logic       loadUseHazard;
  logic       insertBubble;
  logic [1:0] nextForwardRs;
  logic [1:0] nextForwardRt;

  // Register 0 is hard-wired to zero, so a write to it never produces a value.
  function automatic logic regMatch(input slotT s,
                                    input logic [REG_ADDR_WIDTH-1:0] r);
    return s.valid && s.writes && (s.dest == r) && (r != '0);
  endfunction

  // Newest producer wins: EX (about to be in MEM) beats MEM (about to be in
  // WB). A load in EX cannot forward yet; that case is covered by the stall.
  function automatic logic [1:0] selectFor(input logic readsReg,
                                           input logic [REG_ADDR_WIDTH-1:0] r,
                                           input slotT exSlot,
                                           input slotT memSlot);
    logic [1:0] sel;
    sel = FwdRegFile;
    if (readsReg && regMatch(exSlot, r) && !exSlot.isLoad) begin
      sel = FwdMem;
    end else if (readsReg && regMatch(memSlot, r)) begin
      sel = FwdWb;
    end
    return sel;
  endfunction

  always_comb begin
    idSlot        = '0;
    idSlot.valid  = idValid;
    idSlot.writes = idWritesRegister;
    idSlot.isLoad = idIsLoad;
    idSlot.dest   = idDestination;

    // A taken branch squashes the consumer, so it must not also stall:
    // that would cost a second bubble for an instruction that is discarded.
    loadUseHazard = idValid && !branchTaken && pipe[SlotEx].isLoad &&
                    ((idUsesRs && regMatch(pipe[SlotEx], idRs)) ||
                     (idUsesRt && regMatch(pipe[SlotEx], idRt)));

    insertBubble  = loadUseHazard || branchTaken || !idValid;

    nextForwardRs = selectFor(idUsesRs, idRs, pipe[SlotEx], pipe[SlotMem]);
    nextForwardRt = selectFor(idUsesRt, idRt, pipe[SlotEx], pipe[SlotMem]);
  end

  // Gated with rst_n so both controls read 0 while reset is held, even if
  // branchTaken is being driven by a stage that is not itself in reset.
  assign shouldStall = rst_n && loadUseHazard;
  assign shouldFlush = rst_n && branchTaken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        pipe[i] <= '0;
      end
      forwardRs  <= FwdRegFile;
      forwardRt  <= FwdRegFile;
      stallCount <= '0;
    end else begin
      pipe[SlotWb]  <= pipe[SlotMem];
      pipe[SlotMem] <= pipe[SlotEx];
      if (insertBubble) begin
        pipe[SlotEx] <= '0;
        forwardRs    <= FwdRegFile;
        forwardRt    <= FwdRegFile;
      end else begin
        pipe[SlotEx] <= idSlot;
        forwardRs    <= nextForwardRs;
        forwardRt    <= nextForwardRt;
      end
      if (loadUseHazard && (stallCount != '1)) begin
        stallCount <= stallCount + STALL_COUNT_WIDTH'(1);
      end
    end
  end

endmodule
